// File: rtl/muladd_pkg.sv
// Shared types and constants for the time-multiplexed multiply-add array.
package muladd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } muladd_state_t;

  localparam int MULADD_PIPE_DEPTH = 3;
  localparam int MULADD_AW = 27;
  localparam int MULADD_BW = 18;
  localparam int MULADD_PW = 48;

  // Accept edge to out_valid, in enabled cycles: one issue per channel plus the pipe.
  function automatic int muladd_latency(input int nch);
    return nch + MULADD_PIPE_DEPTH;
  endfunction

endpackage

// File: rtl/muladd_tdm_array_if.sv
// Batch handshake bundle between a kernel (master) and the multiply-add array (slave).
interface muladd_tdm_array_if
  import muladd_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = MULADD_AW,
  parameter int BW  = MULADD_BW,
  parameter int PW  = MULADD_PW
);
  logic              in_valid;
  logic              in_ready;
  logic              acc_mode;
  logic [NCH*AW-1:0] a;
  logic [NCH*BW-1:0] b;
  logic [NCH*PW-1:0] c;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*PW-1:0] dout;
  logic              busy;

  modport master (
    output in_valid, acc_mode, a, b, c, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, acc_mode, a, b, c, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/muladd_pipe.sv
// Three-stage signed p = a*b + c with clock enable; valid and tag ride alongside the data.
(* use_dsp = "yes" *)
module muladd_pipe #(
  parameter int AW = 27,
  parameter int BW = 18,
  parameter int PW = 48,
  parameter int TW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [TW-1:0]        in_tag,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [PW-1:0] c,
  output logic                 out_valid,
  output logic [TW-1:0]        out_tag,
  output logic signed [PW-1:0] p
);
  logic                    s1_v, s2_v, s3_v;
  logic [TW-1:0]           s1_tag, s2_tag, s3_tag;
  logic signed [AW-1:0]    s1_a;
  logic signed [BW-1:0]    s1_b;
  logic signed [PW-1:0]    s1_c, s2_c, s3_p;
  logic signed [AW+BW-1:0] s2_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
      s1_tag <= '0; s2_tag <= '0; s3_tag <= '0;
      s1_a <= '0; s1_b <= '0; s1_c <= '0;
      s2_m <= '0; s2_c <= '0; s3_p <= '0;
    end else if (ce) begin
      s1_v   <= in_valid;
      s1_tag <= in_tag;
      s1_a   <= a;
      s1_b   <= b;
      s1_c   <= c;
      s2_v   <= s1_v;
      s2_tag <= s1_tag;
      // Both factors widened to the full product width so the multiply is exact.
      s2_m   <= $signed({{BW{s1_a[AW-1]}}, s1_a}) * $signed({{AW{s1_b[BW-1]}}, s1_b});
      s2_c   <= s1_c;
      s3_v   <= s2_v;
      s3_tag <= s2_tag;
      s3_p   <= PW'(s2_m) + s2_c;
    end
  end

  assign out_valid = s3_v;
  assign out_tag   = s3_tag;
  assign p         = s3_p;
endmodule

// File: rtl/muladd_tdm_array.sv
// NCH signed a*b+c channels issued one per cycle through a single shared multiply-add pipe,
// with an optional per-channel accumulate mode that feeds back each channel's last result.
module muladd_tdm_array
  import muladd_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = MULADD_AW,
  parameter int BW  = MULADD_BW,
  parameter int PW  = MULADD_PW
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_ce,
  muladd_tdm_array_if.slave bus
);
  localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;

  muladd_state_t        state_reg, state_next;
  logic [TW-1:0]        cnt_reg;
  logic                 mode_reg;
  logic signed [AW-1:0] a_reg   [NCH];
  logic signed [BW-1:0] b_reg   [NCH];
  logic signed [PW-1:0] c_reg   [NCH];
  logic signed [PW-1:0] acc_reg [NCH];
  logic signed [PW-1:0] res_reg [NCH];

  logic                 accept, issue_en, last_issue, last_collect;
  logic signed [PW-1:0] c_sel;
  logic                 pipe_v;
  logic [TW-1:0]        pipe_tag;
  logic signed [PW-1:0] pipe_p;

  assign accept       = bus.in_valid & bus.in_ready;
  assign last_issue   = (cnt_reg == TW'(NCH - 1));
  assign last_collect = pipe_v & (pipe_tag == TW'(NCH - 1));
  assign c_sel        = mode_reg ? acc_reg[cnt_reg] : c_reg[cnt_reg];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_reg <= IDLE;
    else if (ap_ce) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_collect) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    issue_en      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bus.in_ready = ap_ce;
        bus.busy     = 1'b0;
      end
      ISSUE:   issue_en = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt_reg  <= '0;
      mode_reg <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        c_reg[i]   <= '0;
        acc_reg[i] <= '0;
        res_reg[i] <= '0;
      end
    end else if (ap_ce) begin
      if (accept) begin
        cnt_reg  <= '0;
        mode_reg <= bus.acc_mode;
        for (int i = 0; i < NCH; i++) begin
          a_reg[i] <= bus.a[i*AW +: AW];
          b_reg[i] <= bus.b[i*BW +: BW];
          c_reg[i] <= bus.c[i*PW +: PW];
        end
      end else if (issue_en) begin
        cnt_reg <= last_issue ? '0 : cnt_reg + 1'b1;
      end
      if (pipe_v) acc_reg[pipe_tag] <= pipe_p;
      // Snapshot the whole batch at once so dout stays put while the next batch runs.
      if (last_collect) begin
        for (int i = 0; i < NCH - 1; i++) res_reg[i] <= acc_reg[i];
        res_reg[NCH-1] <= pipe_p;
      end
    end
  end

  muladd_pipe #(.AW(AW), .BW(BW), .PW(PW), .TW(TW)) u_pipe (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .ce        (ap_ce),
    .in_valid  (issue_en),
    .in_tag    (cnt_reg),
    .a         (a_reg[cnt_reg]),
    .b         (b_reg[cnt_reg]),
    .c         (c_sel),
    .out_valid (pipe_v),
    .out_tag   (pipe_tag),
    .p         (pipe_p)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
    assign bus.dout[gi*PW +: PW] = res_reg[gi];
  end
endmodule

// File: doc/muladd_tdm_array.md
Name: muladd_tdm_array

Overview:
- Parametrised successor to the dual muladd block: NCH signed a*b+c channels time-multiplexed onto one pipelined multiply-add datapath on a single clock.
- Uses a valid/ready batch handshake instead of a 2x clock.
- Adds a per-channel accumulate mode: c is replaced by the channel's previous result.
- Sits between HLS-generated kernels and the DSP column as a drop-in DSP-saving arithmetic unit.

Parameters:
- NCH, 4, number of channels per batch (>=2).
- AW, 27, signed width of each a operand.
- BW, 18, signed width of each b operand.
- PW, 48, signed width of c and of each result; AW+BW <= PW required.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_ce  in  1  global clock enable; low freezes every register.
- in_valid  in  1  batch offered.
- in_ready  out  1  batch accepted on an edge where in_valid & in_ready.
- acc_mode  in  1  sampled with the batch; 1 = use the per-channel accumulator as c.
- a  in  NCH*AW  packed, channel 0 in LSBs.
- b  in  NCH*BW  packed, channel 0 in LSBs.
- c  in  NCH*PW  packed, channel 0 in LSBs.
- out_valid  out  1  result batch available.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- dout  out  NCH*PW  packed results, channel 0 in LSBs.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - in_ready=1 once ap_ce is high; out_valid=0; dout=0; busy=0.
  - All accumulators, pipeline registers and channel counters are cleared to 0.
- States: IDLE, ISSUE, DRAIN, DONE. All transitions and register updates occur only on edges with ap_ce=1.
- in_ready = (state==IDLE) & ap_ce.
- IDLE:
  - On accept, latch a, b, c and acc_mode into batch registers.
  - Clear issue count to 0 and go to ISSUE.
- ISSUE:
  - Each enabled edge loads stage-1 with channel k = issue count, and increments the count.
  - Stage-1 loads a[k], b[k], c'[k] and tag k. c'[k] = acc[k] if latched acc_mode, else c[k].
  - After channel NCH-1 is loaded, go to DRAIN.
- Datapath (sub-module), 3 registered stages:
  - S1: operand registers.
  - S2: m = a*b, full signed AW+BW bits.
  - S3: p = sext(m) + c', modulo 2^PW, two's-complement wrap with no saturation.
  - Tag and valid bits travel alongside the data.
- Collect:
  - On each edge where the S3 valid bit is set, write p into result[tag] and acc[tag].
  - When tag==NCH-1 is written, go to DONE.
- Latency: out_valid rises exactly NCH+3 enabled cycles after the acceptance edge (7 for NCH=4). Each cycle with ap_ce=0 adds exactly one cycle.
- DONE:
  - out_valid=1; dout = result array.
  - dout and out_valid stay stable until the handshake edge, then go to IDLE.
  - After the handshake, out_valid=0 and dout holds its last value.
  - No same-cycle new accept: in_ready stays 0 in DONE.
- Throughput: one batch per NCH+5 cycles with no backpressure.
- Simultaneous events:
  - in_valid while not in IDLE is ignored, with no side effects.
  - A change in acc_mode or in the operands after acceptance has no effect.
- Accumulator update: acc[k] is updated by every completed batch, in both modes.
- Reset mid-operation: aborts immediately, discards in-flight data and clears accumulators. No out_valid is produced for the aborted batch.

Decomposition:
- Shared package muladd_pkg holds:
  - The state enum (IDLE/ISSUE/DRAIN/DONE).
  - MULADD_PIPE_DEPTH=3.
  - A constant function for the latency NCH+3.
  - The default widths 27/18/48.
- Sub-module muladd_pipe(AW,BW,PW,TW): 3-stage signed a*b+c with ce, valid and a TW-bit tag passthrough, marked for DSP inference.
- The top level holds the FSM, issue counter, batch registers, result array and accumulators.

Test Plan:
- Basic batch (NCH=4, acc_mode=0): a={1,2,3,4}, b=10 for all channels, c={0,1,2,3} -> dout={10,21,32,43}, out_valid high exactly 7 cycles after accept; in_ready low throughout.
- Signed and wrap (acc_mode=0):
  - ch0: a=-1, b=-131072, c=0 -> 131072.
  - ch1: a=1, b=1, c=2^47-1 -> 48'h8000_0000_0000 (wrap).
  - ch2: a=-67108864, b=131071, c=0 -> -8796025913344.
  - ch3: all operands 0 -> 0.
- Accumulate: after the basic batch, send a=1, b=1, c=999 for all channels with acc_mode=1 -> dout={11,22,33,44}; the c input is ignored.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and dout stable; in_valid pulses ignored; accept occurs only after the out handshake plus one cycle.
- Clock enable: drop ap_ce for 3 cycles during ISSUE (after channel 1 is issued) -> results identical to the basic batch; out_valid rises at accept+10.
- Reset mid-DRAIN: assert ap_rst asynchronously -> out_valid=0, busy=0, dout=0 immediately; in_ready=1 after release. A following acc_mode=1 batch with a=b=0 -> dout all 0.
